crc16_tx_framer: RTL and testbench
==================================

Name: crc16_tx_framer

Overview:
Byte-stream framer that sits directly upstream of the link serializer. It passes each upstream frame through unchanged and appends a 2-byte CRC-16 trailer, high byte first. The CRC is computed on the fly over every payload byte, so no frame buffering is needed. Valid/ready handshake on both sides, with one byte per cycle during payload.

Parameters:
POLY, 16'h8005, generator polynomial x^16+x^15+x^2+1 (x^16 term implicit)
INIT, 16'hFFFF, CRC register value at reset and at every frame start
CNT_W, 16, width of frame_cnt

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream byte valid
in_ready  out  1  framer accepts byte this cycle
in_data  in  8  payload byte
in_last  in  1  marks final payload byte of frame
out_valid  out  1  output byte valid
out_ready  in  1  downstream accepts output byte
out_data  out  8  payload or CRC byte
out_last  out  1  marks CRC low byte (frame end)
frame_cnt  out  CNT_W  completed frames, wraps modulo 2^CNT_W
busy  out  1  high when state != IDLE or out_valid

Behaviour:
- Reset (rst_n low, async): state=IDLE, crc=INIT, out_valid=0, out_data=0, out_last=0, frame_cnt=0.
- Output slot: a single register (out_valid/out_data/out_last).
  - slot_free = !out_valid || out_ready.
  - While out_valid && !out_ready, out_data and out_last are held stable.
  - If the slot is free and nothing is loaded, out_valid clears.
- in_ready = slot_free && (state==IDLE || state==DATA). It is combinational from out_ready and has no other combinational dependency.
- CRC step per byte is MSB-first, Galois left shift, no reflection, no final XOR. For each bit i = 7 down to 0:
  - fb = crc[15] ^ d[i]
  - crc = {crc[14:0],1'b0} ^ (fb ? POLY : 0)
- This is CRC-16/CMS; the check value for ASCII "123456789" is 16'hAEE7.
- States and transitions:
  - IDLE / DATA, on input accept (in_valid && in_ready):
    - out_data <= in_data, out_valid <= 1, out_last <= 0
    - crc <= step(crc, in_data)
    - next state is CRC_HI if in_last, else DATA
  - CRC_HI, when slot_free: out_data <= crc[15:8], out_valid <= 1, out_last <= 0; go to CRC_LO.
  - CRC_LO, when slot_free:
    - out_data <= crc[7:0], out_valid <= 1, out_last <= 1
    - crc <= INIT, frame_cnt <= frame_cnt + 1
    - go to IDLE
- Latency: an accepted input byte appears on out_data on the next cycle.
- CRC_HI follows the cycle after the last byte is presented, provided the slot is free. The CRC register already includes the last byte at that point.
- Throughput: 1 byte/cycle while in DATA. Each frame costs exactly 2 input-stall cycles (CRC_HI, CRC_LO) under no backpressure. A new frame may be accepted in the cycle after CRC_LO loads.
- A frame is at least 1 byte (in_last on the first byte is legal and gives a 3-byte output). Zero-length frames cannot be expressed.
- in_data and in_last are ignored when in_valid=0 or in_ready=0. Upstream must hold them until accepted.
- Reset mid-frame aborts the frame with no trailer, and the partial CRC is discarded.
- frame_cnt increments on CRC_LO load, not on downstream acceptance of the last byte.
- frame_cnt wraps from all-ones to 0.

Decomposition:
- Package crc16_pkg holds:
  - state enum {IDLE, DATA, CRC_HI, CRC_LO}
  - constants CRC16_POLY=16'h8005, CRC16_INIT=16'hFFFF, CRC16_CHECK=16'hAEE7
  - function crc16_step(crc, byte, poly), an 8-iteration loop, shareable with the receive-side checker
- One sub-module is natural: crc16_byte_step, purely combinational, ports crc_in[15:0], data[7:0], crc_out[15:0]. The framer instantiates it once.

Test Plan:
- Single frame "123456789" (0x31..0x39, last on 0x39), out_ready=1 -> 11 output bytes: the 9 payload bytes, then 0xAE, 0xE7; out_last only on 0xE7; frame_cnt=1; in_ready low exactly 2 cycles.
- Two back-to-back "123456789" frames, in_valid held high -> both trailers 0xAE,0xE7, confirming the INIT reload; frame_cnt=2; no bubble besides the 2 trailer cycles.
- Same frame with out_ready driven by a random 50% pattern -> identical 11-byte sequence. out_data/out_last stay stable whenever out_valid && !out_ready. No byte is dropped or duplicated.
- 1-byte frame for each value 0x00..0xFF -> 3 output bytes each; trailer matches the bitwise model of crc16_step(16'hFFFF, b).
- rst_n pulsed low after 4 payload bytes -> out_valid=0 and frame_cnt=0 immediately (async); a following "123456789" frame yields 0xAE,0xE7.
- With CNT_W=2, send 5 one-byte frames -> frame_cnt reads 1,2,3,0,1; busy deasserts only after the last 0xE7-position byte is accepted.

Source files
------------

// File: rtl/crc16_pkg.sv
// CRC-16/CMS definitions shared by the transmit framer and the receive-side checker.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents: framer state enum, polynomial/init/check constants, byte-wise CRC step.
package crc16_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        CRC_HI = 2'd2,
        CRC_LO = 2'd3
    } state_t;

    localparam logic [15:0] CRC16_POLY  = 16'h8005;
    localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
    // Residue of ASCII "123456789" from CRC16_INIT; handy for self-test on either side.
    localparam logic [15:0] CRC16_CHECK = 16'hAEE7;

    // One byte through the CRC register, MSB first, Galois left shift,
    // no reflection and no final XOR.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic [7:0]  data,
                                               input logic [15:0] poly);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? poly : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_byte_step.sv
// Combinational CRC-16 update of one payload byte.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when to register crc_out.
//
// Ports: crc_in  - current CRC register
//        data    - payload byte, consumed MSB first
//        crc_out - CRC after absorbing data
module crc16_byte_step
    import crc16_pkg::*;
#(
    parameter logic [15:0] POLY = CRC16_POLY
) (
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    assign crc_out = crc16_step(crc_in, data, POLY);

endmodule

// File: rtl/crc16_tx_framer.sv
// Passes each byte-stream frame through and appends a CRC-16 trailer, high byte first.
// Latency: accepted byte appears on out_data the next cycle; trailer follows the last byte.
// Backpressure: single output register; in_ready drops when it is full or during the trailer.
//
// Ports: clk/rst_n                      - clock, async active-low reset
//        in_valid/in_ready/in_data/in_last     - upstream payload, in_last on final byte
//        out_valid/out_ready/out_data/out_last - downstream bytes, out_last on CRC low byte
//        frame_cnt                      - completed frames (counted at CRC low-byte load), wraps
//        busy                           - frame in progress or output byte still pending
module crc16_tx_framer
    import crc16_pkg::*;
#(
    parameter logic [15:0] POLY  = CRC16_POLY,
    parameter logic [15:0] INIT  = CRC16_INIT,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             busy
);

    state_t           state_q;
    state_t           state_d;
    logic [15:0]      crc_q;
    logic [15:0]      crc_d;
    logic [15:0]      crc_next;
    logic             out_valid_d;
    logic [7:0]       out_data_d;
    logic             out_last_d;
    logic [CNT_W-1:0] frame_cnt_d;
    logic             slot_free;
    logic             in_acc;

    crc16_byte_step #(
        .POLY (POLY)
    ) u_step (
        .crc_in  (crc_q),
        .data    (in_data),
        .crc_out (crc_next)
    );

    // The output register can take a new byte if empty or being drained this cycle.
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = slot_free && ((state_q == IDLE) || (state_q == DATA));
    assign in_acc    = in_valid && in_ready;
    assign busy      = (state_q != IDLE) || out_valid;

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        // Held while stalled downstream, cleared once drained with nothing new to load.
        out_valid_d = out_valid && !out_ready;
        out_data_d  = out_data;
        out_last_d  = out_last;
        frame_cnt_d = frame_cnt;

        case (state_q)
            IDLE, DATA: begin
                if (in_acc) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_data;
                    out_last_d  = 1'b0;
                    crc_d       = crc_next;
                    state_d     = in_last ? CRC_HI : DATA;
                end
            end
            CRC_HI: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = crc_q[15:8];
                    out_last_d  = 1'b0;
                    state_d     = CRC_LO;
                end
            end
            CRC_LO: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = crc_q[7:0];
                    out_last_d  = 1'b1;
                    // Re-seed here so the next frame can start the following cycle.
                    crc_d       = INIT;
                    frame_cnt_d = frame_cnt + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            crc_q     <= INIT;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_last  <= out_last_d;
            frame_cnt <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_crc16_tx_framer.sv
// Directed bench for crc16_tx_framer: scoreboard of expected output words,
// immediate-assertion checks, narrow frame counter so the wrap is reachable.
module tb_crc16_tx_framer;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = 8'h00;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       out_data;
    logic             out_last;
    logic [CNT_W-1:0] frame_cnt;
    logic             busy;

    int         vectors = 0;
    int         miscompares = 0;
    int         stalls = 0;
    logic [8:0] sb[$];
    logic [7:0] fr[$];
    bit         rand_rdy = 1'b0;
    logic       rdy_fix = 1'b1;
    bit         prev_hold = 1'b0;
    logic [8:0] prev_word = 9'h000;

    crc16_tx_framer #(
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bitwise reference of the CRC-16/CMS byte update.
    function automatic logic [15:0] model_crc(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    // out_ready source: random or fixed, updated just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
    end

    // Output monitor: pops the scoreboard on each handshake, checks hold stability.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_word", 32'({out_last, out_data}), 32'(prev_word));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 1);
                else check("out_word", 32'({out_last, out_data}), 32'(sb.pop_front()));
            end
            prev_hold = out_valid && !out_ready;
            prev_word = {out_last, out_data};
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end else begin
                stalls++;
            end
        end
        if (!done) check("accept_timeout", 32'(done), 1);
        else sb.push_back({1'b0, d});
    endtask

    task automatic send_frame(input logic [15:0] exp_crc);
        for (int i = 0; i < fr.size(); i++) send_byte(fr[i], i == fr.size() - 1);
        sb.push_back({1'b0, exp_crc[15:8]});
        sb.push_back({1'b1, exp_crc[7:0]});
    endtask

    task automatic load_digits();
        fr.delete();
        for (int i = 0; i < 9; i++) fr.push_back(8'(8'h31 + i));
    endtask

    task automatic go_idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 600 && !ok; t++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !out_valid) ok = 1'b1;
        end
        if (!ok) check("drain_timeout", 32'(ok), 1);
    endtask

    initial begin
        int n;
        bit seen;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single "123456789" frame, no backpressure
        load_digits();
        stalls = 0;
        send_frame(16'hAEE7);
        check("payload_stalls", 32'(stalls), 0);
        go_idle();
        n = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        check("trailer_stall_cycles", 32'(n), 2);
        wait_drain();
        check("cnt_after_1", 32'(frame_cnt), 1);
        check("busy_after_1", 32'(busy), 0);

        // Two back-to-back frames with in_valid held high
        stalls = 0;
        send_frame(16'hAEE7);
        send_frame(16'hAEE7);
        go_idle();
        check("b2b_stalls", 32'(stalls), 2);
        wait_drain();
        check("cnt_after_3", 32'(frame_cnt), 3);

        // Reset mid-frame after 4 payload bytes
        for (int i = 0; i < 4; i++) send_byte(8'(8'h41 + i), 1'b0);
        rst_n = 1'b0;
        go_idle();
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_frame_cnt", 32'(frame_cnt), 0);
        check("midrst_busy", 32'(busy), 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(16'hAEE7);
        go_idle();
        wait_drain();
        check("cnt_after_rst_frame", 32'(frame_cnt), 1);

        // Random downstream backpressure
        rand_rdy = 1'b1;
        send_frame(16'hAEE7);
        go_idle();
        wait_drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        check("cnt_after_rand", 32'(frame_cnt), 2);

        // Every one-byte frame value
        for (int b = 0; b < 256; b++) begin
            fr.delete();
            fr.push_back(8'(b));
            send_frame(model_crc(16'hFFFF, 8'(b)));
        end
        go_idle();
        wait_drain();
        check("cnt_after_256", 32'(frame_cnt), 2);

        // Counter wrap from a clean reset: 1,2,3,0 then 1 on the fifth frame
        rst_n = 1'b0;
        #1;
        check("rst2_frame_cnt", 32'(frame_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 4; k++) begin
            fr.delete();
            fr.push_back(8'(k));
            send_frame(model_crc(16'hFFFF, 8'(k)));
            go_idle();
            wait_drain();
            check("wrap_cnt", 32'(frame_cnt), 32'(k % 4));
            check("wrap_busy", 32'(busy), 0);
        end

        // Fifth frame with downstream stalled, then released
        rdy_fix = 1'b0;
        @(posedge clk);
        #1;
        fr.delete();
        fr.push_back(8'h05);
        send_frame(model_crc(16'hFFFF, 8'h05));
        go_idle();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("stall_busy", 32'(busy), 1);
        check("stall_out_valid", 32'(out_valid), 1);
        check("stall_cnt_unchanged", 32'(frame_cnt), 0);
        rdy_fix = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (out_valid && out_last && out_ready) seen = 1'b1;
        end
        check("last_seen", 32'(seen), 1);
        check("busy_at_last", 32'(busy), 1);
        @(posedge clk);
        #1;
        check("busy_after_last", 32'(busy), 0);
        check("cnt_after_5", 32'(frame_cnt), 1);
        check("sb_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
